// File: rtl/axis_skid_pipeline.sv
// axis_skid_pipeline: D-stage AXI-Stream register pipeline for {data, last, user}.
// REG_READY=0 builds bubble-collapsing stages whose ready ripples combinationally
// from m_rdy; REG_READY=1 builds skid-buffered stages whose ready comes from a flop.
// A synchronous flush drops every held beat, and occ tracks the beats held.
module axis_skid_pipeline #(
    parameter int unsigned D         = 1,
    parameter int unsigned W         = 32,
    parameter int unsigned U         = 1,
    parameter int unsigned REG_READY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    input  logic [U-1:0] s_user,
    input  logic         s_vld,
    output logic         s_rdy,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic [U-1:0] m_user,
    output logic         m_vld,
    input  logic         m_rdy,
    output logic [7:0]   occ
);
    localparam int unsigned P = W + 1 + U;

    generate
        if (D == 0) begin : g_pass
            assign m_data = s_data;
            assign m_last = s_last;
            assign m_user = s_user;
            assign m_vld  = s_vld;
            assign s_rdy  = m_rdy && !rst;
            assign occ    = '0;
        end else begin : g_pipe
            logic [P-1:0] s_pay;
            logic [P-1:0] main_pay [D];
            logic [P-1:0] skid_pay [D];
            logic [P-1:0] up_pay   [D];
            logic [D-1:0] main_v;
            logic [D-1:0] skid_v;
            logic [D-1:0] up_v;
            logic [D-1:0] rdy_in;
            logic [D-1:0] dn_rdy;
            logic         s_fire;
            logic         m_fire;

            assign s_pay  = {s_data, s_last, s_user};
            assign s_rdy  = rdy_in[0] && !flush && !rst;
            assign m_vld  = main_v[D-1];
            assign m_data = main_pay[D-1][P-1 -: W];
            assign m_last = main_pay[D-1][U];
            assign m_user = main_pay[D-1][U-1:0];
            assign s_fire = s_vld && s_rdy;
            assign m_fire = m_vld && m_rdy;

            // Upstream view of each stage: stage 0 sees the slave port, stage k sees stage k-1.
            always_comb begin
                up_v      = main_v << 1;
                up_v[0]   = s_vld;
                up_pay[0] = s_pay;
                for (int unsigned i = 1; i < D; i++) begin
                    up_pay[i] = main_pay[i-1];
                end
            end

            // Ready chain walked from the master end; a local carry keeps it free of self-loops.
            always_comb begin
                logic r;
                logic nr;
                int unsigned k;
                rdy_in = '0;
                dn_rdy = '0;
                r      = m_rdy;
                for (int unsigned i = 0; i < D; i++) begin
                    k         = D - 1 - i;
                    dn_rdy[k] = r;
                    nr        = (REG_READY != 0) ? !skid_v[k] : (!main_v[k] || r);
                    rdy_in[k] = nr;
                    r         = nr;
                end
            end

            // Stage registers: bubble-collapsing load or main/skid slot management.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_v <= '0;
                    skid_v <= '0;
                    for (int unsigned i = 0; i < D; i++) begin
                        main_pay[i] <= '0;
                        skid_pay[i] <= '0;
                    end
                end else if (flush) begin
                    main_v <= '0;
                    skid_v <= '0;
                end else begin
                    for (int unsigned i = 0; i < D; i++) begin
                        if (REG_READY == 0) begin
                            if (rdy_in[i]) begin
                                main_v[i]   <= up_v[i];
                                main_pay[i] <= up_pay[i];
                            end
                        end else if (main_v[i] && dn_rdy[i]) begin
                            // Draining: refill from skid first, otherwise from upstream.
                            if (skid_v[i]) begin
                                main_pay[i] <= skid_pay[i];
                                skid_v[i]   <= 1'b0;
                            end else begin
                                main_v[i]   <= up_v[i];
                                main_pay[i] <= up_pay[i];
                            end
                        end else if (!main_v[i]) begin
                            main_v[i]   <= up_v[i];
                            main_pay[i] <= up_pay[i];
                        end else if (up_v[i] && rdy_in[i]) begin
                            skid_v[i]   <= 1'b1;
                            skid_pay[i] <= up_pay[i];
                        end
                    end
                end
            end

            // Occupancy: +1 per accepted beat, -1 per delivered beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    occ <= '0;
                end else if (flush) begin
                    occ <= '0;
                end else if (s_fire && !m_fire) begin
                    occ <= occ + 8'd1;
                end else if (!s_fire && m_fire) begin
                    occ <= occ - 8'd1;
                end
            end
        end
    endgenerate
endmodule

// File: doc/axis_skid_pipeline.md
# axis_skid_pipeline

Parametrised AXI-Stream register pipeline of D stages carrying data, last and user sidebands at one beat per clock. A mode parameter selects either bubble-collapsing stages, where ready is combinational through the chain, or skid-buffered stages, where ready is registered so no combinational path runs from m_rdy to s_rdy. It adds a synchronous flush and a live occupancy count. It sits between AXI-Stream producers and consumers wherever timing closure needs registers on the valid/data and/or ready paths.

## Interface
- D, 1: pipeline depth in stages, 0..64; 0 = combinational pass-through.
- W, 32: data width, ≥1.
- U, 1: user sideband width, ≥1.
- REG_READY, 1: 0 = bubble-collapsing stages; 1 = skid-buffered stages with registered ready.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all held beats.
- s_data  in  W  upstream data.
- s_last  in  1  upstream end-of-packet.
- s_user  in  U  upstream user sideband.
- s_vld  in  1  upstream valid.
- s_rdy  out  1  upstream ready.
- m_data  out  W  downstream data.
- m_last  out  1  downstream end-of-packet.
- m_user  out  U  downstream user sideband.
- m_vld  out  1  downstream valid.
- m_rdy  in  1  downstream ready.
- occ  out  8  number of beats currently held.

## Operation
- Handshakes:
  - A transfer occurs on a side when vld && rdy in the same cycle.
  - {data, last, user} always move as one unit.
- D=0:
  - m_* = s_*; s_rdy = m_rdy && !rst; occ = 0.
  - flush has no effect.
- REG_READY=0, stage k:
  - Holds one register slot {payload, v}.
  - rdy_in[k] = !v[k] || rdy_in[k+1], with rdy_in[D] = m_rdy.
  - When rdy_in[k] is high, the stage loads its upstream v and payload.
  - Capacity D beats.
- REG_READY=1, stage k:
  - Holds a main slot and a skid slot.
  - rdy_out = !skid_v, driven straight from a flop.
  - Input accepted while main empty, or main draining this cycle: written to main.
  - Input accepted while main full and not draining: written to skid.
  - Main drains while skid full: skid moves to main and skid_v clears.
  - Stage output is always the main slot.
  - Capacity 2D beats.
- occ:
  - +1 on each s-side transfer, −1 on each m-side transfer; both in one cycle = no change.
  - Never exceeds D (REG_READY=0) or 2D (REG_READY=1).
- flush:
  - s_rdy is forced 0 during the flush cycle.
  - An m-side transfer in the flush cycle still completes normally.
  - On the next edge, all v, skid_v and occ clear to 0. Payload registers need not be cleared.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.

## Timing
- Reset values, while rst is high:
  - all v = 0, skid_v = 0, occ = 0, m_vld = 0.
  - m_data, m_last and m_user are 0.
  - s_rdy is forced 0.
- First cycle after rst deassertion: s_rdy = 1 for D>0.
- Latency: a beat accepted at edge n appears on m_* at cycle n+D when downstream is not stalled, in both modes.
- Throughput: 1 beat/clk sustained with m_rdy held high.
- Reset mid-stream: held beats are lost; m_vld drops asynchronously.
- Output stability: while m_vld && !m_rdy, m_* stay stable until accepted (AXI rule). Flush is the only exception.
- Combinational paths:
  - REG_READY=1: s_rdy depends only on flops.
  - REG_READY=0: s_rdy may depend combinationally on m_rdy.

## Test plan
- Streaming: D=3, REG_READY=1, stream 0x00..0x0F with s_vld and m_rdy held 1 -> first m_vld 3 cycles after first accept; 16 beats in order at 1/clk; s_last on beat 15 appears on m_last of the 16th output.
- Full backpressure, REG_READY=1: D=2, m_rdy=0, s_vld=1 -> exactly 4 beats accepted; s_rdy then 0; occ=4. Release m_rdy -> 4 beats out in order, then s_rdy=1.
- Full backpressure, REG_READY=0: same stimulus with REG_READY=0 -> 2 beats accepted; occ=2.
- Bubble collapse: D=4, REG_READY=0, one beat accepted then s_vld=0, m_rdy=0 -> s_rdy stays 1 until 4 beats are held.
- Random stress: random s_vld and m_rdy (50%) for 10,000 beats, D=5 and U=4, in both modes -> scoreboard shows no loss, duplication or reorder; occ always matches the scoreboard count; m_* stable while stalled.
- Flush: flush pulsed with 3 beats held and m_rdy=0 -> s_rdy=0 that cycle; next cycle m_vld=0 and occ=0. A new beat 0xAA then emerges after D cycles.
- Reset mid-stream: rst asserted mid-stream -> m_vld and s_rdy go 0 immediately; after release occ=0 and s_rdy=1.
